// File: rtl/dtcm_pkg.sv
// Shared definitions for the DTCM store buffer: execute-stage mem-op
// encodings, store-size enum and the buffered entry layout.
package dtcm_pkg;

  localparam logic [3:0] MINST_SB   = 4'b1000;
  localparam logic [3:0] MINST_SH   = 4'b1001;
  localparam logic [3:0] MINST_SW   = 4'b1010;
  localparam logic [3:0] MINST_NONE = 4'b1100;

  typedef enum logic [1:0] {
    SZ_B    = 2'b00,
    SZ_H    = 2'b01,
    SZ_W    = 2'b10,
    SZ_NONE = 2'b11
  } st_size_e;

  // One pending store: word address plus already lane-aligned strobe/data.
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } stb_entry_t;

  // Decode the store size carried by a mem-op; loads and no-ops give SZ_NONE.
  function automatic st_size_e minst_size(input logic [3:0] minst);
    st_size_e sz;
    case (minst)
      MINST_SB: sz = SZ_B;
      MINST_SH: sz = SZ_H;
      MINST_SW: sz = SZ_W;
      default:  sz = SZ_NONE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/st_align.sv
// Store lane alignment: turns a byte address offset, store size and source
// register value into DTCM byte enables and lane-replicated write data.
module st_align
  import dtcm_pkg::*;
(
  input  st_size_e    size,
  input  logic [1:0]  byte_off,
  input  logic [31:0] data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  // Select byte enables and replicate the source into every lane it may hit.
  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0000_0000;
    case (size)
      SZ_B: begin
        wstrb = 4'b0001 << byte_off;
        wdata = {4{data[7:0]}};
      end
      SZ_H: begin
        wstrb = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
      end
      SZ_W: begin
        wstrb = 4'b1111;
        wdata = data;
      end
      default: begin
        wstrb = 4'b0000;
        wdata = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/dtcm_store_buf.sv
// DTCM store buffer: FIFO of aligned stores that drains into the DTCM in
// cycles not used by an unstalled load. Loads that hit a pending store's
// word are stalled until that word has been written.
// Optional feature: define DTCM_STBUF_BYPASS_EN to let a store arriving at
// an empty buffer write the DTCM in its own cycle instead of enqueueing.
module dtcm_store_buf
  import dtcm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  minst,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        stall,
  output logic        dtcm_we,
  output logic [3:0]  dtcm_wstrb,
  output logic [31:0] dtcm_waddr,
  output logic [31:0] dtcm_wdata,
  output logic        stb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  stb_entry_t       entry_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic       is_st_s;
  logic       is_ld_s;
  logic       raw_hit_s;
  logic       empty_s;
  logic       full_s;
  logic       drain_s;
  logic       stall_s;
  logic       accept_s;
  logic       bypass_s;
  logic       push_s;
  st_size_e   size_s;
  logic [3:0] al_wstrb_s;
  logic [31:0] al_wdata_s;
  stb_entry_t new_entry_s;
  stb_entry_t head_s;

  st_align u_st_align (
    .size     (size_s),
    .byte_off (st_addr[1:0]),
    .data     (st_data),
    .wstrb    (al_wstrb_s),
    .wdata    (al_wdata_s)
  );

  // Classify the current mem-op and build the entry a store would occupy.
  always_comb begin
    is_st_s     = (minst[3:2] == 2'b10);
    is_ld_s     = (minst[3] == 1'b0);
    size_s      = minst_size(minst);
    new_entry_s = '{addr: st_addr[31:2], wstrb: al_wstrb_s, wdata: al_wdata_s};
  end

  // Read-after-write hazard: a load whose word matches any valid entry.
  always_comb begin
    raw_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      raw_hit_s = raw_hit_s | (is_ld_s & valid_r[i] & (entry_r[i].addr == st_addr[31:2]));
    end
  end

  // Drain/stall/accept decisions; unstalled loads own the DTCM port.
  always_comb begin
    empty_s  = (count_r == CNT_W'(0));
    full_s   = (count_r == CNT_W'(DEPTH));
    drain_s  = ~empty_s & ~(is_ld_s & ~raw_hit_s);
    stall_s  = raw_hit_s | (is_st_s & full_s & ~drain_s);
    accept_s = is_st_s & ~stall_s;
`ifdef DTCM_STBUF_BYPASS_EN
    bypass_s = accept_s & empty_s;
`else
    bypass_s = 1'b0;
`endif
    push_s   = accept_s & ~bypass_s;
    head_s   = entry_r[rd_ptr_r];
  end

  // DTCM write port: the FIFO head, or the incoming store when it bypasses.
  always_comb begin
    stall     = stall_s;
    stb_empty = empty_s;
    dtcm_we   = drain_s | bypass_s;
    if (bypass_s) begin
      dtcm_waddr = {new_entry_s.addr, 2'b00};
      dtcm_wstrb = new_entry_s.wstrb;
      dtcm_wdata = new_entry_s.wdata;
    end else begin
      dtcm_waddr = {head_s.addr, 2'b00};
      dtcm_wstrb = head_s.wstrb;
      dtcm_wdata = head_s.wdata;
    end
  end

  // FIFO state: pop on drain, push on non-bypassed accept, both when both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      if (drain_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s) begin
        entry_r[wr_ptr_r] <= new_entry_s;
        valid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_dtcm_store_buf.sv
// Self-checking bench for dtcm_store_buf: a queue-based model of the store
// buffer is compared against the DUT every cycle, with literal spot checks.
module tb_dtcm_store_buf;

  localparam int DEPTH = 2;
`ifdef DTCM_STBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [3:0] OP_LB   = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SB   = 4'b1000;
  localparam logic [3:0] OP_SH   = 4'b1001;
  localparam logic [3:0] OP_SW   = 4'b1010;
  localparam logic [3:0] OP_NONE = 4'b1100;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  minst;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        stall;
  logic        dtcm_we;
  logic [3:0]  dtcm_wstrb;
  logic [31:0] dtcm_waddr;
  logic [31:0] dtcm_wdata;
  logic        stb_empty;

  dtcm_store_buf #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .minst      (minst),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .stall      (stall),
    .dtcm_we    (dtcm_we),
    .dtcm_wstrb (dtcm_wstrb),
    .dtcm_waddr (dtcm_waddr),
    .dtcm_wdata (dtcm_wdata),
    .stb_empty  (stb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [3:0]  strb;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  logic        s_stall, s_we, s_empty;
  logic [3:0]  s_wstrb;
  logic [31:0] s_waddr, s_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Alignment rules expressed arithmetically (replication by multiplication).
  function automatic ent_t align(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    e.wa = a[31:2];
    case (op)
      OP_SB: begin
        e.strb = 4'(1 << a[1:0]);
        e.data = {24'h0, d[7:0]} * 32'h0101_0101;
      end
      OP_SH: begin
        e.strb = a[1] ? 4'b1100 : 4'b0011;
        e.data = {16'h0, d[15:0]} * 32'h0001_0001;
      end
      OP_SW: begin
        e.strb = 4'b1111;
        e.data = d;
      end
      default: begin
        e.strb = 4'b0000;
        e.data = 32'h0;
      end
    endcase
    return e;
  endfunction

  // One clock: check outputs at the falling edge, advance model at the rising edge.
  task automatic do_cycle();
    bit   is_st, is_ld, raw, drain, stl, accept, byp;
    ent_t ne;
    @(negedge clk);
    is_st = (minst[3:2] == 2'b10);
    is_ld = (minst[3] == 1'b0);
    raw = 1'b0;
    foreach (q[i]) if (is_ld && q[i].wa == st_addr[31:2]) raw = 1'b1;
    drain  = (q.size() > 0) && !(is_ld && !raw);
    stl    = raw || (is_st && q.size() == DEPTH && !drain);
    accept = is_st && !stl && reset;
    byp    = BYP && accept && q.size() == 0;
    ne     = align(minst, st_addr, st_data);
    s_stall = stall; s_we = dtcm_we; s_empty = stb_empty;
    s_wstrb = dtcm_wstrb; s_waddr = dtcm_waddr; s_wdata = dtcm_wdata;
    check("stall", {31'h0, s_stall}, {31'h0, stl});
    check("stb_empty", {31'h0, s_empty}, {31'h0, q.size() == 0});
    check("dtcm_we", {31'h0, s_we}, {31'h0, drain || byp});
    if (drain) begin
      check("waddr", s_waddr, {q[0].wa, 2'b00});
      check("wstrb", {28'h0, s_wstrb}, {28'h0, q[0].strb});
      check("wdata", s_wdata, q[0].data);
    end else if (byp) begin
      check("byp_waddr", s_waddr, {ne.wa, 2'b00});
      check("byp_wstrb", {28'h0, s_wstrb}, {28'h0, ne.strb});
      check("byp_wdata", s_wdata, ne.data);
    end
    @(posedge clk);
    if (reset) begin
      if (drain) void'(q.pop_front());
      if (accept && !byp) q.push_back(ne);
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    minst = op; st_addr = a; st_data = d;
    do_cycle();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] d;
  } vec_t;

  vec_t vecs[] = '{
    '{OP_SB, 32'h0000_0101, 32'hFFFF_FF3C},
    '{OP_LB, 32'h0000_0101, 32'h0},
    '{OP_LB, 32'h0000_0101, 32'h0},
    '{OP_SH, 32'h0000_0203, 32'h1111_BEEF},
    '{OP_LW, 32'h0000_0900, 32'h0},
    '{OP_LW, 32'h0000_0904, 32'h0},
    '{OP_SW, 32'h0000_0303, 32'hCAFE_F00D},
    '{OP_SB, 32'h0000_0302, 32'h0000_0077},
    '{OP_LW, 32'h0000_0300, 32'h0},
    '{OP_LW, 32'h0000_0300, 32'h0},
    '{OP_SW, 32'h0000_0010, 32'h1},
    '{OP_SW, 32'h0000_0014, 32'h2},
    '{OP_SW, 32'h0000_0018, 32'h3},
    '{OP_NONE, 32'h0, 32'h0},
    '{OP_NONE, 32'h0, 32'h0}
  };

  initial begin
    bit done;
    reset = 1'b0; minst = OP_NONE; st_addr = 32'h0; st_data = 32'h0;
    do_cycle();
    check("rst_we", {31'h0, s_we}, 32'h0);
    check("rst_empty", {31'h0, s_empty}, 32'h1);
    check("rst_stall", {31'h0, s_stall}, 32'h0);
    reset = 1'b1;
    do_cycle();

    // SB to 0x103 with 0xA5.
    drive(OP_SB, 32'h0000_0103, 32'h0000_00A5);
    if (!BYP) begin
      check("sb_accept_we", {31'h0, s_we}, 32'h0);
      drive(OP_NONE, 32'h0, 32'h0);
    end
    check("sb_we", {31'h0, s_we}, 32'h1);
    check("sb_waddr", s_waddr, 32'h0000_0100);
    check("sb_wstrb", {28'h0, s_wstrb}, 32'h8);
    check("sb_wdata", s_wdata, 32'hA5A5_A5A5);
    drive(OP_NONE, 32'h0, 32'h0);

    // SH 0x200 then LW 0x200: the load waits for the halfword to drain.
    drive(OP_SH, 32'h0000_0200, 32'h0000_1234);
    minst = OP_LW; st_addr = 32'h0000_0200;
    do_cycle();
    if (!BYP) begin
      check("raw_stall", {31'h0, s_stall}, 32'h1);
      check("raw_we", {31'h0, s_we}, 32'h1);
      check("raw_wstrb", {28'h0, s_wstrb}, 32'h3);
      check("raw_wdata", s_wdata, 32'h1234_1234);
    end
    done = !s_stall;
    for (int k = 0; k < 8 && !done; k++) begin
      do_cycle();
      done = !s_stall;
    end
    check("raw_release_bound", {31'h0, done}, 32'h1);
    check("raw_release_we", {31'h0, s_we}, 32'h0);

`ifdef DTCM_STBUF_BYPASS_EN
    drive(OP_SW, 32'h0000_0040, 32'hDEAD_BEEF);
    check("byp_we", {31'h0, s_we}, 32'h1);
    check("byp_empty", {31'h0, s_empty}, 32'h1);
    check("byp_wdata_lit", s_wdata, 32'hDEAD_BEEF);
`endif

    // Directed mix; stalled vectors are re-presented until accepted.
    foreach (vecs[i]) begin
      minst = vecs[i].op; st_addr = vecs[i].a; st_data = vecs[i].d;
      do_cycle();
      done = !s_stall;
      for (int k = 0; k < 8 && !done; k++) begin
        do_cycle();
        done = !s_stall;
      end
      check("vec_stall_bound", {31'h0, done}, 32'h1);
    end

    // Reset while a store is pending: nothing reaches the DTCM afterwards.
    drive(OP_SW, 32'h0000_0080, 32'h5555_AAAA);
    minst = OP_LW; st_addr = 32'h0000_0A00;
    #2 reset = 1'b0;
    q.delete();
    #1;
    check("midrst_we", {31'h0, dtcm_we}, 32'h0);
    check("midrst_empty", {31'h0, stb_empty}, 32'h1);
    minst = OP_NONE;
    do_cycle();
    reset = 1'b1;
    do_cycle();
    check("post_rst_we", {31'h0, s_we}, 32'h0);
    do_cycle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
